// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of one zero-wait memory.
// A losing request is parked in a hold register and replayed ahead of new traffic.
module ahb_mem_arbiter (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [31:0] S_HWDATA,
    input  logic [31:0] S_HRDATA,
    output logic        S_HREADY,
    output logic [1:0]  grant_owner,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {PS_IDLE, PS_HELD, PS_HDATA} port_state_t;

    logic [1:0][31:0] m_haddr;
    logic [1:0][1:0]  m_htrans;
    logic [1:0]       m_hwrite;
    logic [1:0][2:0]  m_hsize;
    logic [1:0][31:0] m_hrdata;

    logic [1:0][31:0] sel_addr;
    logic [1:0]       sel_write;
    logic [1:0][2:0]  sel_size;

    logic [1:0] live;
    logic [1:0] held;
    logic [1:0] hready;
    logic [1:0] win;
    logic [1:0] dp_eff;

    logic        rr_favor_m1_reg;
    logic [1:0]  dp_owner_reg;
    logic [15:0] stall_cnt_reg;
    logic [16:0] stall_sum;

    assign m_haddr  = {M1_HADDR, M0_HADDR};
    assign m_htrans = {M1_HTRANS, M0_HTRANS};
    assign m_hwrite = {M1_HWRITE, M0_HWRITE};
    assign m_hsize  = {M1_HSIZE, M0_HSIZE};

    // Reset masks every request and data-phase owner so outputs are quiet during reset.
    assign dp_eff = HRESET ? 2'b00 : dp_owner_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            port_state_t state_reg;
            port_state_t state_next;
            logic [31:0] hold_addr_reg;
            logic        hold_write_reg;
            logic [2:0]  hold_size_reg;

            assign held[gi]   = !HRESET && (state_reg == PS_HELD);
            assign hready[gi] = !held[gi];
            assign live[gi]   = !HRESET && hready[gi] && m_htrans[gi][1];

            assign sel_addr[gi]  = held[gi] ? hold_addr_reg  : m_haddr[gi];
            assign sel_write[gi] = held[gi] ? hold_write_reg : m_hwrite[gi];
            assign sel_size[gi]  = held[gi] ? hold_size_reg  : m_hsize[gi];
            assign m_hrdata[gi]  = dp_eff[gi] ? S_HRDATA : 32'h0;

            always_comb begin
                state_next = PS_IDLE;
                case (state_reg)
                    PS_HELD: state_next = win[gi] ? PS_HDATA : PS_HELD;
                    default: state_next = (live[gi] && !win[gi]) ? PS_HELD : PS_IDLE;
                endcase
            end

            always_ff @(posedge HCLK) begin
                if (HRESET) begin
                    state_reg      <= PS_IDLE;
                    hold_addr_reg  <= 32'h0;
                    hold_write_reg <= 1'b0;
                    hold_size_reg  <= 3'b000;
                end else begin
                    state_reg <= state_next;
                    if (live[gi] && !win[gi]) begin
                        hold_addr_reg  <= m_haddr[gi];
                        hold_write_reg <= m_hwrite[gi];
                        hold_size_reg  <= m_hsize[gi];
                    end
                end
            end
        end
    endgenerate

    // Held requests outrank live ones; equal-class ties go to the port not served last.
    always_comb begin
        win = 2'b00;
        if (held != 2'b00) begin
            if (held == 2'b11) win = rr_favor_m1_reg ? 2'b10 : 2'b01;
            else               win = held;
        end else if (live == 2'b11) begin
            win = rr_favor_m1_reg ? 2'b10 : 2'b01;
        end else begin
            win = live;
        end
    end

    always_comb begin
        S_HTRANS = 2'b00;
        S_HADDR  = 32'h0;
        S_HWRITE = 1'b0;
        S_HSIZE  = 3'b000;
        if (win[1]) begin
            S_HTRANS = 2'b10;
            S_HADDR  = sel_addr[1];
            S_HWRITE = sel_write[1];
            S_HSIZE  = sel_size[1];
        end else if (win[0]) begin
            S_HTRANS = 2'b10;
            S_HADDR  = sel_addr[0];
            S_HWRITE = sel_write[0];
            S_HSIZE  = sel_size[0];
        end
    end

    assign S_HWDATA    = dp_eff[1] ? M1_HWDATA : (dp_eff[0] ? M0_HWDATA : 32'h0);
    assign M0_HRDATA   = m_hrdata[0];
    assign M1_HRDATA   = m_hrdata[1];
    assign M0_HREADY   = hready[0];
    assign M1_HREADY   = hready[1];
    assign S_HREADY    = 1'b1;
    assign grant_owner = win;
    assign stall_cnt   = stall_cnt_reg;

    assign stall_sum = {1'b0, stall_cnt_reg} + {16'h0, ~hready[0]} + {16'h0, ~hready[1]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_favor_m1_reg <= 1'b0;
            dp_owner_reg    <= 2'b00;
            stall_cnt_reg   <= 16'h0;
        end else begin
            dp_owner_reg <= win;
            if (win == 2'b01) rr_favor_m1_reg <= 1'b1;
            if (win == 2'b10) rr_favor_m1_reg <= 1'b0;
            stall_cnt_reg <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed self-checking bench for ahb_mem_arbiter: reset, single master,
// contention, round-robin, held priority, reset while held, counter saturation.
module tb_ahb_mem_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, S_HRDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [31:0] M0_HRDATA, M1_HRDATA, S_HADDR, S_HWDATA;
    logic        M0_HREADY, M1_HREADY, S_HWRITE, S_HREADY;
    logic [1:0]  S_HTRANS, grant_owner;
    logic [2:0]  S_HSIZE;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_mem_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY),
        .grant_owner(grant_owner), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        M0_HADDR = 32'h0; M0_HTRANS = 2'b00; M0_HWRITE = 1'b0; M0_HSIZE = 3'b010; M0_HWDATA = 32'h0;
        M1_HADDR = 32'h0; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HSIZE = 3'b010; M1_HWDATA = 32'h0;
        S_HRDATA = 32'h0;
    endtask

    task automatic drive_m0(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        M0_HTRANS = trans; M0_HADDR = addr; M0_HWRITE = wr;
    endtask

    task automatic drive_m1(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
        M1_HTRANS = trans; M1_HADDR = addr; M1_HWRITE = wr;
    endtask

    task automatic apply_reset();
        HRESET = 1'b1;
        idle_inputs();
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        idle_inputs();
        drive_m0(2'b10, 32'h100, 1'b0);
        drive_m1(2'b10, 32'h200, 1'b1);
        M0_HWDATA = 32'h5555_AAAA;
        S_HRDATA = 32'h1234_5678;
        tick();
        tick();
        #1;
        checks++; if (S_HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%0h exp=0", S_HTRANS); end
        checks++; if (grant_owner !== 2'b00) begin failures++; $display("FAIL rst_grant got=%0h exp=0", grant_owner); end
        checks++; if (S_HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%0h exp=0", S_HADDR); end
        checks++; if (M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) begin failures++; $display("FAIL rst_hready got=%b%b exp=11", M1_HREADY, M0_HREADY); end
        checks++; if (M0_HRDATA !== 32'h0 || M1_HRDATA !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%0h/%0h exp=0/0", M0_HRDATA, M1_HRDATA); end
        checks++; if (S_HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%0h exp=0", S_HWDATA); end
        HRESET = 1'b0;
        idle_inputs();
        tick();
        #1;
        checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL rst_stall_cnt got=%0h exp=0", stall_cnt); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_single();
        apply_reset();
        drive_m0(2'b10, 32'h100, 1'b0);
        #1;
        checks++; if (S_HADDR !== 32'h100) begin failures++; $display("FAIL single_haddr got=%0h exp=100", S_HADDR); end
        checks++; if (S_HTRANS !== 2'b10 || grant_owner !== 2'b01) begin failures++; $display("FAIL single_grant got=%0h/%0h exp=2/1", S_HTRANS, grant_owner); end
        tick();
        idle_inputs();
        S_HRDATA = 32'hCAFE_0001;
        #1;
        checks++; if (M0_HRDATA !== 32'hCAFE_0001) begin failures++; $display("FAIL single_hrdata got=%0h exp=cafe0001", M0_HRDATA); end
        checks++; if (M1_HRDATA !== 32'h0) begin failures++; $display("FAIL single_m1_hrdata got=%0h exp=0", M1_HRDATA); end
        checks++; if (M0_HREADY !== 1'b1 || stall_cnt !== 16'h0) begin failures++; $display("FAIL single_ready got=%b/%0h exp=1/0", M0_HREADY, stall_cnt); end
        checks++; if (S_HTRANS !== 2'b00) begin failures++; $display("FAIL single_idle got=%0h exp=0", S_HTRANS); end
        $display("test_single done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_contention();
        apply_reset();
        drive_m0(2'b10, 32'h0, 1'b1);
        drive_m1(2'b10, 32'h4, 1'b1);
        #1;
        checks++; if (grant_owner !== 2'b01 || S_HADDR !== 32'h0 || S_HWRITE !== 1'b1) begin failures++; $display("FAIL cont_c0 got=%0h/%0h/%b exp=1/0/1", grant_owner, S_HADDR, S_HWRITE); end
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        M0_HWDATA = 32'hAAAA_0000;
        M1_HWDATA = 32'h1111_1111;
        #1;
        checks++; if (S_HADDR !== 32'h4 || grant_owner !== 2'b10) begin failures++; $display("FAIL cont_c1_addr got=%0h/%0h exp=4/2", S_HADDR, grant_owner); end
        checks++; if (M1_HREADY !== 1'b0 || M0_HREADY !== 1'b1) begin failures++; $display("FAIL cont_c1_ready got=%b%b exp=01", M1_HREADY, M0_HREADY); end
        checks++; if (S_HWDATA !== 32'hAAAA_0000) begin failures++; $display("FAIL cont_c1_hwdata got=%0h exp=aaaa0000", S_HWDATA); end
        tick();
        drive_m1(2'b00, 32'h0, 1'b0);
        M0_HWDATA = 32'h0;
        M1_HWDATA = 32'hBBBB_0004;
        #1;
        checks++; if (M1_HREADY !== 1'b1) begin failures++; $display("FAIL cont_c2_ready got=%b exp=1", M1_HREADY); end
        checks++; if (S_HWDATA !== 32'hBBBB_0004) begin failures++; $display("FAIL cont_c2_hwdata got=%0h exp=bbbb0004", S_HWDATA); end
        checks++; if (stall_cnt !== 16'd1 || S_HTRANS !== 2'b00) begin failures++; $display("FAIL cont_c2_stall got=%0h/%0h exp=1/0", stall_cnt, S_HTRANS); end
        $display("test_contention done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_grant;
        logic        exp_r0, exp_r1;
        logic [31:0] exp_addr;
        apply_reset();
        drive_m0(2'b10, 32'h1000, 1'b0);
        drive_m1(2'b11, 32'h2000, 1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            #1;
            exp_grant = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (c % 2 == 0) ? 32'h1000 : 32'h2000;
            exp_r0    = (c >= 2 && c % 2 == 0) ? 1'b0 : 1'b1;
            exp_r1    = (c % 2 == 1) ? 1'b0 : 1'b1;
            checks++; if (grant_owner !== exp_grant || S_HADDR !== exp_addr) begin failures++; $display("FAIL rr_grant c=%0d got=%0h/%0h exp=%0h/%0h", c, grant_owner, S_HADDR, exp_grant, exp_addr); end
            checks++; if (M0_HREADY !== exp_r0 || M1_HREADY !== exp_r1) begin failures++; $display("FAIL rr_ready c=%0d got=%b%b exp=%b%b", c, M1_HREADY, M0_HREADY, exp_r1, exp_r0); end
        end
        $display("test_round_robin done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_held_priority();
        apply_reset();
        drive_m0(2'b10, 32'h10, 1'b0);
        drive_m1(2'b10, 32'h44, 1'b1);
        M1_HSIZE = 3'b001;
        tick();
        drive_m0(2'b10, 32'h20, 1'b0);
        drive_m1(2'b10, 32'h88, 1'b0);
        M1_HSIZE = 3'b010;
        #1;
        checks++; if (grant_owner !== 2'b10 || S_HADDR !== 32'h44) begin failures++; $display("FAIL held_c1_grant got=%0h/%0h exp=2/44", grant_owner, S_HADDR); end
        checks++; if (S_HWRITE !== 1'b1 || S_HSIZE !== 3'b001) begin failures++; $display("FAIL held_c1_ctrl got=%b/%0h exp=1/1", S_HWRITE, S_HSIZE); end
        checks++; if (M0_HREADY !== 1'b1) begin failures++; $display("FAIL held_c1_m0ready got=%b exp=1", M0_HREADY); end
        tick();
        drive_m0(2'b10, 32'h30, 1'b1);
        drive_m1(2'b00, 32'h0, 1'b0);
        #1;
        checks++; if (M0_HREADY !== 1'b0 || M1_HREADY !== 1'b1) begin failures++; $display("FAIL held_c2_ready got=%b%b exp=10", M1_HREADY, M0_HREADY); end
        checks++; if (grant_owner !== 2'b01 || S_HADDR !== 32'h20 || S_HWRITE !== 1'b0) begin failures++; $display("FAIL held_c2_grant got=%0h/%0h/%b exp=1/20/0", grant_owner, S_HADDR, S_HWRITE); end
        tick();
        idle_inputs();
        #1;
        checks++; if (M0_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin failures++; $display("FAIL held_c3_idle got=%b/%0h exp=1/0", M0_HREADY, S_HTRANS); end
        checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL held_c3_stall got=%0h exp=2", stall_cnt); end
        $display("test_held_priority done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_held();
        apply_reset();
        drive_m0(2'b10, 32'h40, 1'b1);
        drive_m1(2'b10, 32'h80, 1'b1);
        tick();
        drive_m0(2'b00, 32'h0, 1'b0);
        HRESET = 1'b1;
        #1;
        checks++; if (M1_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin failures++; $display("FAIL rsth_during got=%b/%0h exp=1/0", M1_HREADY, S_HTRANS); end
        tick();
        HRESET = 1'b0;
        idle_inputs();
        #1;
        checks++; if (M1_HREADY !== 1'b1 || S_HTRANS !== 2'b00 || grant_owner !== 2'b00) begin failures++; $display("FAIL rsth_after got=%b/%0h/%0h exp=1/0/0", M1_HREADY, S_HTRANS, grant_owner); end
        checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL rsth_stall got=%0h exp=0", stall_cnt); end
        tick();
        #1;
        checks++; if (S_HTRANS !== 2'b00 || M1_HREADY !== 1'b1) begin failures++; $display("FAIL rsth_later got=%0h/%b exp=0/1", S_HTRANS, M1_HREADY); end
        $display("test_reset_held done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_saturation();
        apply_reset();
        drive_m0(2'b10, 32'h500, 1'b0);
        drive_m1(2'b10, 32'h600, 1'b0);
        for (int c = 1; c <= 65540; c++) begin
            tick();
            if (c == 1000) begin
                checks++; if (stall_cnt !== 16'd999) begin failures++; $display("FAIL sat_mid got=%0d exp=999", stall_cnt); end
            end
            if (c == 65536) begin
                checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffff", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
        $display("test_saturation done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_held_priority();
        test_reset_held();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
